incrementer_counter: RTL and testbench

//  Registered up-counting counterpart of the 4-bit decrementer.

---
 rtl/incrementer_counter.sv | 77 +++++++
 tb/tb_incrementer_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/incrementer_counter.sv
`default_nettype none
// ============================================================================
// Module      : incrementer_counter
// Description : Registered up-counter with parallel load, synchronous clear,
//               wrap/saturate at MAX_VAL and overflow pulse / sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module incrementer_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             overflow,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_ovf_sticky;

    logic [WIDTH:0]   w_inc;
    logic             w_ovf_hit;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_terminal_next;

    // The carry bit is kept so the terminal test also covers MAX_VAL = 2**WIDTH-1.
    assign w_inc          = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_ovf_hit      = (w_inc > {1'b0, c_max});
    assign w_load_clamped = (load_val > c_max) ? c_max : load_val;

    generate
        if (SATURATE) begin : g_saturate
            assign w_terminal_next = c_max;
        end else begin : g_wrap
            assign w_terminal_next = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else if (load) begin
            r_count    <= w_load_clamped;
            r_overflow <= 1'b0;
        end else if (en) begin
            if (w_ovf_hit) begin
                r_count      <= w_terminal_next;
                r_overflow   <= 1'b1;
                r_ovf_sticky <= 1'b1;
            end else begin
                r_count    <= w_inc[WIDTH-1:0];
                r_overflow <= 1'b0;
            end
        end else begin
            r_overflow <= 1'b0;
        end
    end

    assign count      = r_count;
    assign at_max     = (r_count == c_max);
    assign overflow   = r_overflow;
    assign ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_incrementer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_incrementer_counter
// Description : Directed bench for incrementer_counter (wrap, saturate and
//               MAX_VAL=9 variants) with immediate-assertion checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_incrementer_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr      [3];
    logic       load     [3];
    logic [3:0] load_val [3];
    logic       en       [3];
    logic [3:0] count    [3];
    logic       at_max   [3];
    logic       overflow [3];
    logic       ovf_sticky [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: wrap at 15, u1: saturate at 15, u2: wrap at 9
    incrementer_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .clr(clr[0]), .load(load[0]), .load_val(load_val[0]),
        .en(en[0]), .count(count[0]), .at_max(at_max[0]), .overflow(overflow[0]),
        .ovf_sticky(ovf_sticky[0])
    );
    incrementer_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst), .clr(clr[1]), .load(load[1]), .load_val(load_val[1]),
        .en(en[1]), .count(count[1]), .at_max(at_max[1]), .overflow(overflow[1]),
        .ovf_sticky(ovf_sticky[1])
    );
    incrementer_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u2 (
        .clk(clk), .rst(rst), .clr(clr[2]), .load(load[2]), .load_val(load_val[2]),
        .en(en[2]), .count(count[2]), .at_max(at_max[2]), .overflow(overflow[2]),
        .ovf_sticky(ovf_sticky[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // count, overflow, sticky of instance i in one go
    task automatic chk3(input string tag, input int i, input logic [3:0] c,
                        input logic o, input logic s);
        chk({tag, ".count"},  {4'd0, count[i]},         {4'd0, c});
        chk({tag, ".ovf"},    {7'd0, overflow[i]},      {7'd0, o});
        chk({tag, ".sticky"}, {7'd0, ovf_sticky[i]},    {7'd0, s});
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b0; load[i] = 1'b0; load_val[i] = 4'd0; en[i] = 1'b0;
        end

        // 1: reset, then count up five times
        tick(); tick();
        chk3("reset.u0", 0, 4'd0, 1'b0, 1'b0);
        chk3("reset.u1", 1, 4'd0, 1'b0, 1'b0);
        chk3("reset.u2", 2, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        en[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk3("upcount", 0, 4'(k), 1'b0, 1'b0);
        end
        en[0] = 1'b0;
        tick();
        chk3("hold", 0, 4'd5, 1'b0, 1'b0);

        // 2: load 14, wrap through 15 -> 0 -> 1
        load[0] = 1'b1; load_val[0] = 4'd14;
        tick();
        chk3("load14", 0, 4'd14, 1'b0, 1'b0);
        chk("load14.at_max", {7'd0, at_max[0]}, 8'd0);
        load[0] = 1'b0; en[0] = 1'b1;
        tick();
        chk3("inc15", 0, 4'd15, 1'b0, 1'b0);
        chk("inc15.at_max", {7'd0, at_max[0]}, 8'd1);
        tick();
        chk3("wrap0", 0, 4'd0, 1'b1, 1'b1);
        chk("wrap0.at_max", {7'd0, at_max[0]}, 8'd0);
        tick();
        chk3("after_wrap", 0, 4'd1, 1'b0, 1'b1);
        en[0] = 1'b0;

        // 3: saturating instance, back-to-back overflow then clear
        load[1] = 1'b1; load_val[1] = 4'd15;
        tick();
        chk3("sat.load15", 1, 4'd15, 1'b0, 1'b0);
        load[1] = 1'b0; en[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk3("sat.hold", 1, 4'd15, 1'b1, 1'b1);
        end
        en[1] = 1'b0; clr[1] = 1'b1;
        tick();
        chk3("sat.clr", 1, 4'd0, 1'b0, 1'b0);
        clr[1] = 1'b0;

        // 4: load beats en; clr beats load and en
        load[0] = 1'b1; load_val[0] = 4'd15;
        tick();
        chk3("prio.load15", 0, 4'd15, 1'b0, 1'b1);
        load_val[0] = 4'd3; en[0] = 1'b1;
        tick();
        chk3("prio.load_over_en", 0, 4'd3, 1'b0, 1'b1);
        clr[0] = 1'b1;
        tick();
        chk3("prio.clr", 0, 4'd0, 1'b0, 1'b0);
        clr[0] = 1'b0; load[0] = 1'b0; en[0] = 1'b0;

        // 5: MAX_VAL=9, clamped load then wrap
        load[2] = 1'b1; load_val[2] = 4'd12;
        tick();
        chk3("m9.clamp", 2, 4'd9, 1'b0, 1'b0);
        chk("m9.at_max", {7'd0, at_max[2]}, 8'd1);
        load[2] = 1'b0; en[2] = 1'b1;
        tick();
        chk3("m9.wrap", 2, 4'd0, 1'b1, 1'b1);
        en[2] = 1'b0;
        tick();
        chk3("m9.pulse_end", 2, 4'd0, 1'b0, 1'b1);
        load[2] = 1'b1; load_val[2] = 4'd8;
        tick();
        load[2] = 1'b0; en[2] = 1'b1;
        tick();
        chk3("m9.inc_to9", 2, 4'd9, 1'b0, 1'b1);
        en[2] = 1'b0;

        // 6: rst on the same edge as a pending overflow
        load[0] = 1'b1; load_val[0] = 4'd15;
        tick();
        load[0] = 1'b0; en[0] = 1'b1;
        tick();
        chk3("rst.pre_ovf", 0, 4'd0, 1'b1, 1'b1);
        en[0] = 1'b0; load[0] = 1'b1;
        tick();
        load[0] = 1'b0; en[0] = 1'b1; rst = 1'b1;
        tick();
        chk3("rst.override", 0, 4'd0, 1'b0, 1'b0);
        chk3("rst.u2", 2, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; en[0] = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
